// File: rtl/dmx4_pkg.sv
// Shared types for the dmx4 dispatch slice: destination select, FSM states, credit width.
package dmx4_pkg;

    typedef logic [1:0] dest_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        STALL
    } state_t;

    localparam int unsigned CRED_W = 3;

endpackage

// File: rtl/dmx4_if.sv
// Input stream, demux drive and credit signals of dmx4_dispatch.
// The master side feeds beats and returns credits; the slave side is the dispatcher.
interface dmx4_if #(
    parameter int unsigned W = 1
) ();
    import dmx4_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    dest_t        in_dest;
    logic [W-1:0] dmx_i;
    logic         dmx_s1;
    logic         dmx_s0;
    logic         dmx_valid;
    logic [3:0]   credit_ret;
    logic         stall;
    logic         credit_ovf;

    modport master (
        output in_valid, in_data, in_dest, credit_ret,
        input  in_ready, dmx_i, dmx_s1, dmx_s0, dmx_valid, stall, credit_ovf
    );

    modport slave (
        input  in_valid, in_data, in_dest, credit_ret,
        output in_ready, dmx_i, dmx_s1, dmx_s0, dmx_valid, stall, credit_ovf
    );

endinterface

// File: rtl/dmx4_fifo.sv
// Synchronous FIFO, DEPTH x WIDTH, head word read straight from the storage flops.
// DEPTH must be a power of two so the pointers wrap naturally.
module dmx4_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmx4_dispatch.sv
// In-order credit-gated feeder for the 1:4 demux: FIFO, per-destination credits, issue FSM.
// Optional DMX4_STATS_EN adds 16-bit per-destination issued-beat counters on stat_cnt.
module dmx4_dispatch
    import dmx4_pkg::*;
#(
    parameter int unsigned W       = 1,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CREDITS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    dmx4_if.slave        bus
`ifdef DMX4_STATS_EN
    ,
    output logic [4*16-1:0] stat_cnt
`endif
);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    logic [W+1:0]      head;
    logic              empty, full;
    dest_t             head_dest;
    logic [W-1:0]      head_data;
    logic              issue;
    logic [3:0]        iss_vec;

    logic [CRED_W-1:0] cred_q [4];
    logic [CRED_W-1:0] cred_d [4];
    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [W-1:0]      data_q, data_d;
    dest_t             sel_q, sel_d;
    logic              ovf_q, ovf_d;

    dmx4_fifo #(
        .WIDTH (W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .wdata ({bus.in_dest, bus.in_data}),
        .pop   (issue),
        .rdata (head),
        .empty (empty),
        .full  (full)
    );

    assign head_dest = head[W+1:W];
    assign head_data = head[W-1:0];
    // Issue is decided from the registered head and credits, so a beat pushed at one edge leaves at the next.
    assign issue     = !empty && (cred_q[head_dest] != '0);
    assign iss_vec   = issue ? (4'b0001 << head_dest) : 4'b0000;

    always_comb begin
        cred_d  = cred_q;
        ovf_d   = ovf_q;
        valid_d = issue;
        data_d  = data_q;
        sel_d   = sel_q;
        state_d = IDLE;
        for (int unsigned n = 0; n < 4; n++) begin
            // A return landing on the same destination as an issue cancels it; saturation only applies otherwise.
            if (iss_vec[n[1:0]] && !bus.credit_ret[n[1:0]]) begin
                cred_d[n] = cred_q[n] - 1'b1;
            end else if (!iss_vec[n[1:0]] && bus.credit_ret[n[1:0]]) begin
                if (cred_q[n] == CRED_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cred_d[n] = cred_q[n] + 1'b1;
                end
            end
        end
        if (issue) begin
            data_d  = head_data;
            sel_d   = head_dest;
            state_d = ISSUE;
        end else if (!empty) begin
            state_d = STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cred_q  <= '{default: CRED_MAX};
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cred_q  <= cred_d;
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.dmx_valid  = valid_q;
    assign bus.dmx_i      = data_q;
    assign bus.dmx_s1     = sel_q[1];
    assign bus.dmx_s0     = sel_q[0];
    assign bus.stall      = (state_q == STALL);
    assign bus.credit_ovf = ovf_q;

`ifdef DMX4_STATS_EN
    logic [15:0] stat_q [4];
    logic [15:0] stat_d [4];

    always_comb begin
        stat_d = stat_q;
        if (issue) begin
            stat_d[head_dest] = stat_q[head_dest] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '{default: '0};
        end else begin
            stat_q <= stat_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_stat
        assign stat_cnt[g*16 +: 16] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_dmx4_dispatch.sv
// Self-checking bench for dmx4_dispatch: queue-based reference model, directed scenarios, random traffic.
// Build with DMX4_STATS_EN defined to also check stat_cnt.
module tb_dmx4_dispatch;
    import dmx4_pkg::*;

    localparam int unsigned W       = 1;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CREDITS = 2;

    logic clk = 1'b0;
    logic rst_n;

    dmx4_if #(.W(W)) bus ();

`ifdef DMX4_STATS_EN
    logic [63:0] stat_cnt;
    dmx4_dispatch #(.W(W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_cnt(stat_cnt)
    );
`else
    dmx4_dispatch #(.W(W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endfunction

    // Reference model: a queue of pending beats plus a credit count per destination.
    typedef struct { int dest; int data; } beat_t;
    beat_t q[$];
    int    cred[4];
    bit    m_valid, m_stall, m_ovf;
    int    m_dest, m_data;
    int    m_stat[4];

    function automatic void model_reset();
        q.delete();
        for (int n = 0; n < 4; n++) begin
            cred[n]   = CREDITS;
            m_stat[n] = 0;
        end
        m_valid = 0; m_stall = 0; m_ovf = 0; m_dest = 0; m_data = 0;
    endfunction

    function automatic void model_step();
        int pre = q.size();
        bit iss = (pre > 0) && (cred[q[0].dest] > 0);
        int hd  = (pre > 0) ? q[0].dest : -1;
        for (int n = 0; n < 4; n++) begin
            bit used = iss && (hd == n);
            bit ret  = bus.credit_ret[n];
            if (used && !ret) cred[n] = cred[n] - 1;
            else if (!used && ret) begin
                if (cred[n] == CREDITS) m_ovf = 1;
                else cred[n] = cred[n] + 1;
            end
        end
        m_valid = iss;
        if (iss) begin
            m_dest = q[0].dest;
            m_data = q[0].data;
            m_stat[m_dest] = (m_stat[m_dest] + 1) % 65536;
            void'(q.pop_front());
        end
        m_stall = !iss && (pre > 0);
        if (bus.in_valid && pre < DEPTH) q.push_back('{int'(bus.in_dest), int'(bus.in_data)});
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready",   int'(bus.in_ready),   int'(q.size() < DEPTH));
            check("dmx_valid",  int'(bus.dmx_valid),  int'(m_valid));
            check("dmx_sel",    int'({bus.dmx_s1, bus.dmx_s0}), m_dest);
            check("dmx_i",      int'(bus.dmx_i),      m_data);
            check("stall",      int'(bus.stall),      int'(m_stall));
            check("credit_ovf", int'(bus.credit_ovf), int'(m_ovf));
`ifdef DMX4_STATS_EN
            for (int n = 0; n < 4; n++) check("stat_cnt", int'(stat_cnt[n*16 +: 16]), m_stat[n]);
`endif
        end
    end

    task automatic drive(input bit v, input int data, input int dest, input logic [3:0] ret);
        bus.in_valid   = v;
        bus.in_data    = W'(data);
        bus.in_dest    = dest_t'(dest);
        bus.credit_ret = ret;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        drive(0, 0, 0, 4'b0000);
        chk_on = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_valid", int'(bus.dmx_valid), 0);
        check("rst_sel",   int'({bus.dmx_s1, bus.dmx_s0}), 0);
        check("rst_i",     int'(bus.dmx_i), 0);
        check("rst_stall", int'(bus.stall), 0);
        check("rst_ovf",   int'(bus.credit_ovf), 0);
        check("rst_ready", int'(bus.in_ready), 1);
        rst_n = 1'b1;
        tick(); tick();
        check("idle_valid", int'(bus.dmx_valid), 0);

        // Four destinations back to back, one cycle latency
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, k, 4'b0000);
            tick();
            if (k == 0) check("lat_valid0", int'(bus.dmx_valid), 0);
            else begin
                check("seq_valid", int'(bus.dmx_valid), 1);
                check("seq_sel", int'({bus.dmx_s1, bus.dmx_s0}), k - 1);
            end
        end
        drive(0, 0, 0, 4'b0000);
        tick();
        check("seq_valid3", int'(bus.dmx_valid), 1);
        check("seq_sel3", int'({bus.dmx_s1, bus.dmx_s0}), 3);
        check("seq_i3", int'(bus.dmx_i), 1);
        tick();
        check("hold_valid", int'(bus.dmx_valid), 0);
        check("hold_sel", int'({bus.dmx_s1, bus.dmx_s0}), 3);
        drive(0, 0, 0, 4'b1111); tick();
        drive(0, 0, 0, 4'b0000);

        // Credit exhaustion on dest 2
        for (int k = 0; k < 3; k++) begin
            drive(1, int'($urandom_range(0, 1)), 2, 4'b0000);
            tick();
        end
        drive(0, 0, 0, 4'b0000);
        tick();
        check("stall_on", int'(bus.stall), 1);
        tick();
        check("stall_hold", int'(bus.stall), 1);
        check("stall_novalid", int'(bus.dmx_valid), 0);
        drive(0, 0, 0, 4'b0100); tick();
        check("ret_novalid", int'(bus.dmx_valid), 0);
        drive(0, 0, 0, 4'b0000); tick();
        check("ret_valid", int'(bus.dmx_valid), 1);
        check("ret_sel", int'({bus.dmx_s1, bus.dmx_s0}), 2);
        check("ret_stall", int'(bus.stall), 0);
        drive(0, 0, 0, 4'b0100); tick(); tick();
        drive(0, 0, 0, 4'b0000);

        // Block dest 3 and fill the FIFO, then drain with a credit stream
        for (int k = 0; k < 8; k++) begin
            drive(1, int'($urandom_range(0, 1)), 3, 4'b0000);
            tick();
        end
        check("full_ready", int'(bus.in_ready), 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 4'b1000);
            tick();
            cnt += int'(bus.dmx_valid);
        end
        drive(0, 0, 0, 4'b0000); tick(); tick();
        check("drain_beats", cnt, DEPTH);
        check("drain_ready", int'(bus.in_ready), 1);

        // Overflow is sticky; simultaneous issue and return leaves the credit alone
        check("ovf_clear", int'(bus.credit_ovf), 0);
        drive(0, 0, 0, 4'b0001); tick();
        check("ovf_set", int'(bus.credit_ovf), 1);
        drive(0, 0, 0, 4'b0000); tick(); tick();
        check("ovf_sticky", int'(bus.credit_ovf), 1);
        drive(1, 1, 1, 4'b0000); tick();
        drive(0, 0, 0, 4'b0010); tick();
        check("net0_valid", int'(bus.dmx_valid), 1);
        drive(1, 0, 1, 4'b0000); tick();
        drive(1, 1, 1, 4'b0000); tick();
        cnt = int'(bus.dmx_valid);
        drive(0, 0, 0, 4'b0000);
        tick(); cnt += int'(bus.dmx_valid);
        tick(); cnt += int'(bus.dmx_valid);
        check("net0_beats", cnt, 2);
        check("net0_stall", int'(bus.stall), 0);

        // Reset while draining with beats buffered
        for (int k = 0; k < 6; k++) begin
            drive(1, k % 2, 0, (k == 4) ? 4'b0001 : 4'b0000);
            tick();
        end
        check("pre_rst_valid", int'(bus.dmx_valid), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(bus.dmx_valid), 0);
        check("mid_rst_ready", int'(bus.in_ready), 1);
        check("mid_rst_stall", int'(bus.stall), 0);
        check("mid_rst_ovf", int'(bus.credit_ovf), 0);
`ifdef DMX4_STATS_EN
        check("mid_rst_stat", int'(stat_cnt != 64'd0), 0);
`endif
        drive(0, 0, 0, 4'b0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", int'(bus.dmx_valid), 0);
        drive(1, 1, 0, 4'b0000); tick();
        drive(1, 0, 0, 4'b0000); tick();
        cnt = int'(bus.dmx_valid);
        drive(0, 0, 0, 4'b0000);
        tick(); cnt += int'(bus.dmx_valid);
        check("post_rst_beats", cnt, 2);
        check("post_rst_stall", int'(bus.stall), 0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  4'($urandom & $urandom));
            tick();
        end
        drive(0, 0, 0, 4'b0000);
        tick(); tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
